// File: rtl/and16_bist.sv
// Power-on self-test engine for a 16-bit AND gate: drives A/B vectors, checks Y against A&B.
// Optional first-failure capture ports are enabled by defining AND16_BIST_CAPTURE_EN.
module and16_bist #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] A_o,
    output logic [WIDTH-1:0] B_o,
    input  logic [WIDTH-1:0] Y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [7:0]       err_cnt_o
`ifdef AND16_BIST_CAPTURE_EN
    ,
    output logic [15:0]      fail_idx_o,
    output logic [WIDTH-1:0] fail_a_o,
    output logic [WIDTH-1:0] fail_b_o,
    output logic [WIDTH-1:0] fail_y_o
`endif
);

    localparam int unsigned FIXED_VECTORS = 4;
    localparam int unsigned IDX_W         = 16;
    localparam int unsigned ERR_W         = 8;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
    localparam logic [IDX_W-1:0] FIXED_END = IDX_W'(FIXED_VECTORS);
    localparam logic [15:0]      LFSR_MASK = 16'hB400;
    localparam logic [ERR_W-1:0] ERR_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     index;
    logic [15:0]          lfsr_a;
    logic [15:0]          lfsr_b;

    logic [WIDTH-1:0]     vec_a_c;
    logic [WIDTH-1:0]     vec_b_c;
    logic                 mismatch_c;
    logic [ERR_W-1:0]     err_nxt_c;

    // Galois right-shift step; the low bit feeds back through the tap mask.
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // First four vectors walk the corner cases; index bits select all-zero/all-one operands.
    always_comb begin
        vec_a_c = WIDTH'(lfsr_a);
        vec_b_c = WIDTH'(lfsr_b);
        if (index < FIXED_END) begin
            vec_a_c = {WIDTH{index[1]}};
            vec_b_c = {WIDTH{index[0]}};
        end
    end

    // Any differing bit flags the whole vector once; the counter saturates.
    always_comb begin
        mismatch_c = (Y_i != (A_o & B_o));
        err_nxt_c  = err_cnt_o;
        if (mismatch_c && (err_cnt_o != ERR_MAX)) begin
            err_nxt_c = err_cnt_o + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            index      <= '0;
            lfsr_a     <= SEED;
            lfsr_b     <= ~SEED;
            A_o        <= '0;
            B_o        <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            err_cnt_o  <= '0;
`ifdef AND16_BIST_CAPTURE_EN
            fail_idx_o <= '0;
            fail_a_o   <= '0;
            fail_b_o   <= '0;
            fail_y_o   <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state      <= DRIVE;
                        index      <= '0;
                        lfsr_a     <= SEED;
                        lfsr_b     <= ~SEED;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        pass_o     <= 1'b0;
                        err_cnt_o  <= '0;
`ifdef AND16_BIST_CAPTURE_EN
                        fail_idx_o <= '0;
                        fail_a_o   <= '0;
                        fail_b_o   <= '0;
                        fail_y_o   <= '0;
`endif
                    end
                end
                DRIVE: begin
                    A_o   <= vec_a_c;
                    B_o   <= vec_b_c;
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    err_cnt_o <= err_nxt_c;
`ifdef AND16_BIST_CAPTURE_EN
                    // A zero count means no earlier mismatch in this run.
                    if (mismatch_c && (err_cnt_o == '0)) begin
                        fail_idx_o <= index;
                        fail_a_o   <= A_o;
                        fail_b_o   <= B_o;
                        fail_y_o   <= Y_i;
                    end
`endif
                    index <= index + 16'd1;
                    if (index >= FIXED_END) begin
                        lfsr_a <= lfsr_step(lfsr_a);
                        lfsr_b <= lfsr_step(lfsr_b);
                    end
                    if (index == LAST_IDX) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (err_nxt_c == '0);
                    end else begin
                        state  <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_busy_done_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(busy_o && done_o));
    a_pass_needs_done: assert property (@(posedge clk_i) disable iff (rst_i) pass_o |-> done_o);

endmodule

// File: tb/tb_and16_bist.sv
// Scoreboard bench for and16_bist: stimulus queues expected vectors/results, a monitor checks them.
module tb_and16_bist;

    localparam int unsigned NV  = 64;
    localparam int unsigned NV2 = 300;

    typedef struct {
        logic [7:0] err;
        logic       pass;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        start2;
    logic [15:0] a_o, b_o, y_i;
    logic [15:0] a2, b2, y2;
    logic        busy, done, pass;
    logic        busy2, done2, pass2;
    logic [7:0]  err, err2;
    int          mode;
`ifdef AND16_BIST_CAPTURE_EN
    logic [15:0] fidx, fa, fb, fy;
    logic [15:0] fidx2, fa2, fb2, fy2;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [15:0] va [NV2];
    logic [15:0] vb [NV2];
    logic [31:0] vec_q [$];
    res_t        res_q [$];

    always #5 clk = ~clk;

    // Fault models for the gate under test: golden, Y[0] stuck-at-0, Y tied high.
    assign y_i = (mode == 1) ? (a_o & b_o & 16'hFFFE) :
                 (mode == 2) ? 16'hFFFF : (a_o & b_o);
    assign y2  = 16'h0000;

    and16_bist #(.WIDTH(16), .NUM_VECTORS(NV), .SEED(16'hACE1)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .A_o       (a_o),
        .B_o       (b_o),
        .Y_i       (y_i),
        .busy_o    (busy),
        .done_o    (done),
        .pass_o    (pass),
        .err_cnt_o (err)
`ifdef AND16_BIST_CAPTURE_EN
        ,
        .fail_idx_o(fidx),
        .fail_a_o  (fa),
        .fail_b_o  (fb),
        .fail_y_o  (fy)
`endif
    );

    and16_bist #(.WIDTH(16), .NUM_VECTORS(NV2), .SEED(16'hACE1)) dut_sat (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start2),
        .A_o       (a2),
        .B_o       (b2),
        .Y_i       (y2),
        .busy_o    (busy2),
        .done_o    (done2),
        .pass_o    (pass2),
        .err_cnt_o (err2)
`ifdef AND16_BIST_CAPTURE_EN
        ,
        .fail_idx_o(fidx2),
        .fail_a_o  (fa2),
        .fail_b_o  (fb2),
        .fail_y_o  (fy2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic build_model();
        logic [15:0] la, lb;
        la = 16'hACE1;
        lb = ~16'hACE1;
        for (int k = 0; k < int'(NV2); k++) begin
            if (k < 4) begin
                va[k] = {16{k[1]}};
                vb[k] = {16{k[0]}};
            end else begin
                va[k] = la;
                vb[k] = lb;
                la = lfsr_step(la);
                lb = lfsr_step(lb);
            end
        end
    endtask

    // Queue the vectors and final verdict the monitor should see for one run of dut.
    task automatic push_run(input int m);
        int   n;
        res_t r;
        n = 0;
        for (int k = 0; k < int'(NV); k++) begin
            vec_q.push_back({va[k], vb[k]});
            if (m == 1 && (va[k][0] & vb[k][0])) n++;
            if (m == 2 && ((va[k] & vb[k]) != 16'hFFFF)) n++;
        end
        r.err  = (n > 255) ? 8'hFF : 8'(n);
        r.pass = (n == 0);
        res_q.push_back(r);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles, input int extra_start);
        int i;
        bit seen;
        seen = 1'b0;
        for (i = 1; i <= exp_cycles + 20; i++) begin
            @(posedge clk); #1;
            start_i = (extra_start != 0) && (i == extra_start);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: done_o never rose within %0d cycles", name, exp_cycles + 20);
        end else begin
            check(name, 32'(i), 32'(exp_cycles));
        end
    endtask

    // Monitor: even busy cycles carry a fresh vector; busy falling ends the run.
    int          bcnt = 0;
    logic [31:0] mon_vec;
    res_t        mon_res;
    always @(negedge clk) begin
        if (busy) begin
            bcnt++;
            if (bcnt[0] == 1'b0) begin
                if (vec_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL vec_queue: unexpected vector a=%0h b=%0h", a_o, b_o);
                end else begin
                    mon_vec = vec_q.pop_front();
                    check("vector_a", 32'(a_o), 32'(mon_vec[31:16]));
                    check("vector_b", 32'(b_o), 32'(mon_vec[15:0]));
                end
            end
        end else if (bcnt != 0) begin
            if (done) begin
                if (res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res_queue: run ended with no expected result");
                end else begin
                    mon_res = res_q.pop_front();
                    check("run_err_cnt", 32'(err), 32'(mon_res.err));
                    check("run_pass", 32'(pass), 32'(mon_res.pass));
                    check("busy_cycles", 32'(bcnt), 32'(2 * NV));
                end
            end else begin
                vec_q.delete();
                if (res_q.size() != 0) mon_res = res_q.pop_front();
            end
            bcnt = 0;
        end
    end

    initial begin
        int n2;
        int i2;
        bit seen2;
        rst_i   = 1'b1;
        start_i = 1'b0;
        start2  = 1'b0;
        mode    = 0;
        build_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", 32'(a_o), 32'h0);
        check("rst_b", 32'(b_o), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pass", 32'(pass), 32'h0);
        check("rst_err", 32'(err), 32'h0);
`ifdef AND16_BIST_CAPTURE_EN
        check("rst_fail_idx", 32'(fidx), 32'h0);
        check("rst_fail_y", 32'(fy), 32'h0);
`endif
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("idle_no_start", 32'(busy), 32'h0);

        // Golden gate
        mode = 0;
        push_run(0);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'h1);
        wait_done("golden_latency", 2 * NV, 0);
        check("golden_pass", 32'(pass), 32'h1);
`ifdef AND16_BIST_CAPTURE_EN
        check("golden_fail_idx", 32'(fidx), 32'h0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 32'(done), 32'h1);
        check("done_hold_a", 32'(a_o), 32'(va[NV-1]));
        check("done_hold_b", 32'(b_o), 32'(vb[NV-1]));

        // Y[0] stuck-at-0, with a start pulse at cycle 10 that must be ignored
        mode = 1;
        push_run(1);
        pulse_start();
        wait_done("stuck_latency", 2 * NV, 10);
        check("stuck_pass", 32'(pass), 32'h0);
`ifdef AND16_BIST_CAPTURE_EN
        check("cap_idx", 32'(fidx), 32'h3);
        check("cap_a", 32'(fa), 32'hFFFF);
        check("cap_b", 32'(fb), 32'hFFFF);
        check("cap_y", 32'(fy), 32'hFFFE);
`endif

        // Restart from DONE clears status on the next cycle and reruns identically
        push_run(1);
        pulse_start();
        check("restart_err_clr", 32'(err), 32'h0);
        check("restart_done_clr", 32'(done), 32'h0);
        check("restart_pass_clr", 32'(pass), 32'h0);
`ifdef AND16_BIST_CAPTURE_EN
        check("restart_cap_clr", 32'(fidx), 32'h0);
`endif
        wait_done("rerun_latency", 2 * NV, 0);

        // Y tied high
        mode = 2;
        push_run(2);
        pulse_start();
        wait_done("tied_latency", 2 * NV, 0);

        // Reset 50 cycles into a run aborts it; a fresh run repeats the sequence
        mode = 0;
        push_run(0);
        pulse_start();
        repeat (49) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("abort_a", 32'(a_o), 32'h0);
        check("abort_b", 32'(b_o), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        push_run(0);
        pulse_start();
        wait_done("post_abort_latency", 2 * NV, 0);
        check("post_abort_pass", 32'(pass), 32'h1);

        // 300-vector instance against Y stuck at zero: count saturates
        n2 = 0;
        for (int k = 0; k < int'(NV2); k++) begin
            if ((va[k] & vb[k]) != 16'h0000) n2++;
        end
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        seen2 = 1'b0;
        for (i2 = 1; i2 <= 2 * int'(NV2) + 20; i2++) begin
            @(posedge clk); #1;
            if (done2) begin
                seen2 = 1'b1;
                break;
            end
        end
        if (!seen2) begin
            total++;
            bad++;
            $display("FAIL sat_latency: done_o never rose within %0d cycles", 2 * NV2 + 20);
        end else begin
            check("sat_latency", 32'(i2), 32'(2 * NV2));
        end
        check("sat_err", 32'(err2), (n2 > 255) ? 32'd255 : 32'(n2));
        check("sat_pass", 32'(pass2), 32'h0);
`ifdef AND16_BIST_CAPTURE_EN
        check("sat_cap_idx", 32'(fidx2), 32'h3);
        check("sat_cap_y", 32'(fy2), 32'h0);
`endif

        @(posedge clk); #1;
        check("vec_q_drained", 32'(vec_q.size()), 32'h0);
        check("res_q_drained", 32'(res_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
